accum_arb: RTL and testbench
============================

ACCUM_ARB -- requirements
Module: accum_arb

Interface
REQ-001 Parameter p_width, default 32, data width of every message.
REQ-002 Parameter p_nreqs, default 4, number of requesters sharing the accumulator (2..8).
REQ-003 Parameter p_nmsgs, default 4, messages per accumulation group, matching the shared accumulator.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port req_val  input  p_nreqs  per-requester input-message valid.
REQ-007 Port req_rdy  output  p_nreqs  per-requester input-message ready.
REQ-008 Port req_msg  input  p_nreqs*p_width  packed requester messages; requester i occupies bits [i*p_width +: p_width].
REQ-009 Port resp_val  output  p_nreqs  per-requester result valid.
REQ-010 Port resp_rdy  input  p_nreqs  per-requester result ready.
REQ-011 Port resp_msg  output  p_width  result data, shared by all requesters and qualified by resp_val.
REQ-012 Port acc_req_val / acc_req_rdy / acc_req_msg  output / input / output  1 / 1 / p_width  request stream to the accumulator.
REQ-013 Port acc_resp_val / acc_resp_rdy / acc_resp_msg  input / output / input  1 / 1 / p_width  result stream from the accumulator.
REQ-014 Port grant  output  clog2(p_nreqs)  index of the current owner; valid only while busy is 1.
REQ-015 Port busy  output  1  high in the SEND and WAIT states.

Function
REQ-016 The FSM SHALL have three states: IDLE, SEND and WAIT.
REQ-017 IDLE: if any req_val bit is 1, the block SHALL register the winner of a round-robin choice, starting the search at priority pointer ptr, into grant and go to SEND on the next cycle; all rdy/val outputs SHALL be 0 in IDLE.
REQ-018 SEND: acc_req_val SHALL equal req_val[grant], acc_req_msg SHALL equal req_msg[grant], and req_rdy[grant] SHALL equal acc_req_rdy, all combinationally; all other req_rdy bits SHALL be 0.
REQ-019 SEND: a message counter SHALL increment on each acc_req handshake (val and rdy both 1) and hold during gaps; on the p_nmsgs-th handshake it SHALL clear and the FSM SHALL go to WAIT.
REQ-020 WAIT: resp_val[grant] SHALL equal acc_resp_val, resp_msg SHALL equal acc_resp_msg, and acc_resp_rdy SHALL equal resp_rdy[grant]; all other resp_val bits SHALL be 0.
REQ-021 WAIT: on the acc_resp handshake the block SHALL set ptr to (grant+1) mod p_nreqs and go to IDLE.
REQ-022 A group SHALL never be interleaved with another group: the grant is locked from the entry to SEND until the WAIT handshake.
REQ-023 The minimum overhead SHALL be one IDLE cycle per group, so a new grant is possible on the cycle after the WAIT handshake.
REQ-024 Outside SEND, acc_req_val SHALL be 0; outside WAIT, acc_resp_rdy SHALL be 0.
REQ-025 resp_msg SHALL be 0 whenever no resp_val bit is 1.
REQ-026 A requester that drops val mid-group SHALL keep the grant; the block waits indefinitely and has no timeout.
REQ-027 A requester with no active val SHALL never be granted; if only one requester is active, it SHALL be granted on every group regardless of ptr.

Reset
REQ-028 While reset is 0, the block SHALL asynchronously set state=IDLE, ptr=0, grant=0 and counter=0, which drives all val/rdy outputs, busy and resp_msg to 0.
REQ-029 An in-flight group aborted by reset SHALL be discarded; after reset the accumulator must be reset together with this block.

Structure
REQ-030 The state enum (IDLE, SEND, WAIT) and the clog2-derived index-width constants SHALL live in a shared package, accum_pkg.
REQ-031 The round-robin choice SHALL be a sub-module, accum_rr_arb (inputs: request vector and ptr; outputs: one-hot grant and grant index), which is purely combinational.

Verification
REQ-032 The bench SHALL cover: requester 0 alone sends 5,10,5,10 -> resp_val[0] with resp_msg=30; resp_val[1..3] stay 0.
REQ-033 The bench SHALL cover: requesters 0 and 2 both raise val in the same IDLE cycle with ptr=0 -> requester 0's group (2,10,3,11 -> 26) completes before requester 2's group (18,14,8,4 -> 44) starts, with no interleaving.
REQ-034 The bench SHALL cover: all four requesters continuously valid for 8 groups -> grant order 0,1,2,3,0,1,2,3.
REQ-035 The bench SHALL cover: resp_rdy[grant] held 0 for 5 cycles in WAIT (group 93,13,3,1) -> resp_val and resp_msg=110 held stable, and acc_resp_rdy stays 0 until resp_rdy rises.
REQ-036 The bench SHALL cover: random val gaps and back-pressure on acc_req_rdy and resp_rdy over 100 random 8-bit groups per requester -> every result equals the sum of its four messages and is delivered to its own requester.
REQ-037 The bench SHALL cover: reset asserted after the 2nd message of a group -> outputs go to 0 immediately; after release, a fresh group from requester 1 is granted first only if requester 0 is idle.

Source files
------------

// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_pkg
// Description : Shared definitions for the accumulator arbiter slice:
//               FSM state encoding, index-width helpers and requester limits.
// Revision    : 1.0 - initial release
// ============================================================================
package accum_pkg;

    // FSM state encoding (2-bit, legacy-compatible constants)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

    // Supported requester range and the matching index width
    localparam int MIN_NREQS = 2;
    localparam int MAX_NREQS = 8;
    localparam int MAX_IDX_W = $clog2(MAX_NREQS);

    // Width of an index into n items; never narrower than one bit so that
    // degenerate counters (n == 1) still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/accum_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : accum_rr_arb
// Description : Purely combinational round-robin chooser. The search starts
//               at ptr and wraps; the first requesting index wins.
// Ports       : req        - request vector
//               ptr        - priority pointer (first index searched)
//               gnt_onehot - one-hot winner (all zero when no request)
//               gnt_idx    - binary winner index (0 when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module accum_rr_arb
    import accum_pkg::*;
#(
    parameter int p_nreqs = 4,
    parameter int p_idx_w = idx_width(p_nreqs)
) (
    input  logic [p_nreqs-1:0]  req,
    input  logic [p_idx_w-1:0]  ptr,
    output logic [p_nreqs-1:0]  gnt_onehot,
    output logic [p_idx_w-1:0]  gnt_idx
);

    int w_dist;
    int w_best;

    // The winner is the requester at the smallest wrapped distance from ptr.
    always_comb begin
        w_dist  = 0;
        w_best  = p_nreqs;
        gnt_idx = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + p_nreqs - int'(ptr));
            if (req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                gnt_idx = p_idx_w'(i);
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            gnt_onehot[i] = (|req) && (gnt_idx == p_idx_w'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/accum_arb.sv
`default_nettype none
// ============================================================================
// Module      : accum_arb
// Description : Shares one accumulator between p_nreqs requesters. A winner
//               is chosen round-robin in IDLE, streams p_nmsgs messages to the
//               accumulator in SEND, and receives the single result in WAIT.
//               A group is never interleaved with another group.
// Ports       : clk, reset (async, active-low)
//               req_val/req_rdy/req_msg    - per-requester input streams
//               resp_val/resp_rdy/resp_msg - per-requester results (shared data)
//               acc_req_*  - message stream to the accumulator
//               acc_resp_* - result stream from the accumulator
//               grant      - current owner index (meaningful while busy)
//               busy       - high in SEND and WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module accum_arb
    import accum_pkg::*;
#(
    parameter int p_width = 32,
    parameter int p_nreqs = 4,
    parameter int p_nmsgs = 4
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [p_nreqs-1:0]            req_val,
    output logic [p_nreqs-1:0]            req_rdy,
    input  logic [p_nreqs*p_width-1:0]    req_msg,

    output logic [p_nreqs-1:0]            resp_val,
    input  logic [p_nreqs-1:0]            resp_rdy,
    output logic [p_width-1:0]            resp_msg,

    output logic                          acc_req_val,
    input  logic                          acc_req_rdy,
    output logic [p_width-1:0]            acc_req_msg,

    input  logic                          acc_resp_val,
    output logic                          acc_resp_rdy,
    input  logic [p_width-1:0]            acc_resp_msg,

    output logic [$clog2(p_nreqs)-1:0]    grant,
    output logic                          busy
);

    localparam int c_idx_w = idx_width(p_nreqs);
    localparam int c_cnt_w = idx_width(p_nmsgs);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(p_nmsgs - 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(p_nreqs - 1);

    state_t               r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_grant;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [p_nreqs-1:0]   w_arb_onehot;
    logic [c_idx_w-1:0]   w_arb_idx;
    logic                 w_arb_any;

    logic                 w_in_send;
    logic                 w_in_wait;
    logic [p_nreqs-1:0]   w_own;
    logic                 w_sel_val;
    logic [p_width-1:0]   w_sel_msg;
    logic                 w_sel_rrdy;
    logic                 w_req_hs;
    logic                 w_resp_hs;

    // ------------------------------------------------------------------
    // Round-robin winner for the next group
    // ------------------------------------------------------------------
    accum_rr_arb #(
        .p_nreqs (p_nreqs),
        .p_idx_w (c_idx_w)
    ) u_rr_arb (
        .req        (req_val),
        .ptr        (r_ptr),
        .gnt_onehot (w_arb_onehot),
        .gnt_idx    (w_arb_idx)
    );

    assign w_arb_any = |w_arb_onehot;

    // ------------------------------------------------------------------
    // Owner decode and selection of the owner's stream signals
    // ------------------------------------------------------------------
    always_comb begin
        w_own      = '0;
        w_sel_val  = 1'b0;
        w_sel_msg  = '0;
        w_sel_rrdy = 1'b0;
        for (int i = 0; i < p_nreqs; i++) begin
            w_own[i] = (r_grant == c_idx_w'(i));
            if (w_own[i]) begin
                w_sel_val  = req_val[i];
                w_sel_msg  = req_msg[i*p_width +: p_width];
                w_sel_rrdy = resp_rdy[i];
            end
        end
    end

    assign w_in_send = (r_state == ST_SEND);
    assign w_in_wait = (r_state == ST_WAIT);

    // Pass-through paths are gated by state so that every handshake signal
    // is quiet outside the phase that owns it.
    assign acc_req_val  = w_in_send & w_sel_val;
    assign acc_req_msg  = w_in_send ? w_sel_msg : '0;
    assign acc_resp_rdy = w_in_wait & w_sel_rrdy;
    assign resp_msg     = (w_in_wait & acc_resp_val) ? acc_resp_msg : '0;

    always_comb begin
        req_rdy  = '0;
        resp_val = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            req_rdy[i]  = w_in_send & acc_req_rdy  & w_own[i];
            resp_val[i] = w_in_wait & acc_resp_val & w_own[i];
        end
    end

    assign w_req_hs  = acc_req_val  & acc_req_rdy;
    assign w_resp_hs = acc_resp_val & acc_resp_rdy;

    assign grant = r_grant;
    assign busy  = w_in_send | w_in_wait;

    // ------------------------------------------------------------------
    // Group FSM. The grant is only written in IDLE, which locks the owner
    // from SEND entry until the WAIT handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_grant <= w_arb_idx;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_req_hs) begin
                        if (r_cnt == c_last_cnt) begin
                            r_cnt   <= '0;
                            r_state <= ST_WAIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_resp_hs) begin
                        // Next search starts just after the finished owner
                        r_ptr   <= (r_grant == c_last_idx) ? '0 : (r_grant + 1'b1);
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accum_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_arb
// Description : Self-checking bench for accum_arb. Requester drivers and an
//               accumulator model form the environment; a scoreboard holds the
//               expected per-requester sums and a monitor compares results,
//               round-robin grant order and idle-state output behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_arb;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int M  = 4;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_val;
    logic [N-1:0]      req_rdy;
    logic [N*W-1:0]    req_msg;
    logic [N-1:0]      resp_val;
    logic [N-1:0]      resp_rdy;
    logic [W-1:0]      resp_msg;
    logic              acc_req_val;
    logic              acc_req_rdy;
    logic [W-1:0]      acc_req_msg;
    logic              acc_resp_val;
    logic              acc_resp_rdy;
    logic [W-1:0]      acc_resp_msg;
    logic [IW-1:0]     grant;
    logic              busy;

    accum_arb #(
        .p_width (W),
        .p_nreqs (N),
        .p_nmsgs (M)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .acc_req_val  (acc_req_val),
        .acc_req_rdy  (acc_req_rdy),
        .acc_req_msg  (acc_req_msg),
        .acc_resp_val (acc_resp_val),
        .acc_resp_rdy (acc_resp_rdy),
        .acc_resp_msg (acc_resp_msg),
        .grant        (grant),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus queues and scoreboard
    logic [W-1:0] msg_q [N][$];
    logic [W-1:0] exp_q [N][$];
    int           grant_log [$];

    // Environment knobs
    int           gap_pct;
    int           acc_rdy_pct;
    int           rrdy_pct;
    int           acc_dly_pct;
    logic [N-1:0] hold_mask;

    // Accumulator model state
    int           acc_cnt;
    logic [W-1:0] acc_sum;
    bit           acc_pending;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic bit all_empty();
        for (int r = 0; r < N; r++)
            if (msg_q[r].size() != 0 || exp_q[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // First active requester found walking from p (wrapping)
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (p + k) % N;
            if (v[c[IW-1:0]]) return c;
        end
        return 0;
    endfunction

    task automatic queue_group(input int r, input logic [W-1:0] m0, input logic [W-1:0] m1,
                               input logic [W-1:0] m2, input logic [W-1:0] m3);
        msg_q[r].push_back(m0);
        msg_q[r].push_back(m1);
        msg_q[r].push_back(m2);
        msg_q[r].push_back(m3);
        exp_q[r].push_back(m0 + m1 + m2 + m3);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && !all_empty()) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, "_drained"}, W'(all_empty()), 1);
        repeat (3) @(negedge clk);
        check_eq({name, "_idle_after"}, W'(busy), 0);
    endtask

    task automatic wait_resp(input string name, input int r, input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (n < max_cyc && !resp_val[r]) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, "_resp_seen"}, W'(resp_val[r]), 1);
    endtask

    task automatic quiet_env();
        gap_pct     = 0;
        acc_rdy_pct = 100;
        rrdy_pct    = 100;
        acc_dly_pct = 0;
        hold_mask   = '0;
    endtask

    // ------------------------------------------------------------------
    // Driver: requesters and accumulator model. Handshakes are sampled at
    // the negedge; new input values are applied 1 unit after the posedge.
    // ------------------------------------------------------------------
    initial begin : driver
        bit           req_hs [N];
        bit           a_req_hs;
        bit           a_resp_hs;
        logic [W-1:0] a_msg;
        req_val      = '0;
        req_msg      = '0;
        resp_rdy     = '0;
        acc_req_rdy  = 1'b0;
        acc_resp_val = 1'b0;
        acc_resp_msg = '0;
        acc_cnt      = 0;
        acc_sum      = '0;
        acc_pending  = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) req_hs[i] = req_val[i] && req_rdy[i];
            a_req_hs  = acc_req_val && acc_req_rdy;
            a_msg     = acc_req_msg;
            a_resp_hs = acc_resp_val && acc_resp_rdy;
            @(posedge clk);
            #1;
            if (!reset) begin
                acc_cnt      = 0;
                acc_sum      = '0;
                acc_pending  = 1'b0;
                acc_resp_val = 1'b0;
                acc_resp_msg = '0;
            end else begin
                for (int i = 0; i < N; i++)
                    if (req_hs[i] && msg_q[i].size() > 0) void'(msg_q[i].pop_front());
                if (a_resp_hs) begin
                    acc_pending  = 1'b0;
                    acc_resp_val = 1'b0;
                    acc_resp_msg = '0;
                end
                if (a_req_hs) begin
                    acc_sum = acc_sum + a_msg;
                    acc_cnt++;
                    if (acc_cnt == M) begin
                        acc_pending  = 1'b1;
                        acc_resp_msg = acc_sum;
                        acc_sum      = '0;
                        acc_cnt      = 0;
                    end
                end
                if (acc_pending && !acc_resp_val && !chance(acc_dly_pct)) acc_resp_val = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                req_val[i]          = (msg_q[i].size() > 0) && !chance(gap_pct);
                req_msg[i*W +: W]   = (msg_q[i].size() > 0) ? msg_q[i][0] : '0;
                resp_rdy[i]         = !hold_mask[i] && chance(rrdy_pct);
            end
            acc_req_rdy = !acc_pending && chance(acc_rdy_pct);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: scoreboard compare, round-robin prediction, idle checks
    // ------------------------------------------------------------------
    initial begin : monitor
        bit   pend;
        int   exp_g;
        int   m_ptr;
        int   m_owner;
        bit   prev_busy;
        logic [IW-1:0] prev_grant;
        logic [W-1:0]  exp_v;
        pend = 1'b0; exp_g = 0; m_ptr = 0; m_owner = 0; prev_busy = 1'b0; prev_grant = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 1'b0;
                m_ptr = 0;
                prev_busy = 1'b0;
            end else begin
                if (pend) begin
                    check_eq("grant_taken", W'(busy), 1);
                    check_eq("rr_grant", W'(grant), W'(exp_g));
                    m_owner = exp_g;
                    pend = 1'b0;
                end
                if (busy && !prev_busy) grant_log.push_back(int'(grant));
                if (busy && prev_busy) check_eq("grant_locked", W'(grant), W'(prev_grant));
                if (!busy)
                    check_eq("idle_outputs", W'({req_rdy, resp_val, acc_req_val, acc_resp_rdy}), 0);
                check_eq("resp_val_onehot", W'($countones(resp_val) <= 1), 1);
                if (resp_val == '0) check_eq("resp_msg_zero", resp_msg, 0);
                for (int i = 0; i < N; i++) begin
                    if (resp_val[i] && resp_rdy[i]) begin
                        if (exp_q[i].size() == 0) begin
                            check_eq($sformatf("unexpected_resp_r%0d", i), W'(resp_val), 0);
                        end else begin
                            exp_v = exp_q[i].pop_front();
                            check_eq($sformatf("resp_data_r%0d", i), resp_msg, exp_v);
                        end
                    end
                end
                if (acc_resp_val && acc_resp_rdy) m_ptr = (m_owner + 1) % N;
                if (!busy && req_val != '0) begin
                    pend  = 1'b1;
                    exp_g = rr_pick(req_val, m_ptr);
                end
                prev_busy  = busy;
                prev_grant = grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin : main
        int n;
        quiet_env();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", W'(busy), 0);
        check_eq("reset_grant", W'(grant), 0);
        check_eq("reset_handshakes", W'({req_rdy, resp_val, acc_req_val, acc_resp_rdy}), 0);
        check_eq("reset_resp_msg", resp_msg, 0);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);

        // Two requesters raise val together with ptr at 0
        grant_log.delete();
        queue_group(0, 2, 10, 3, 11);
        queue_group(2, 18, 14, 8, 4);
        wait_drain("two_req", 200);
        check_eq("two_req_groups", W'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            check_eq("two_req_first", W'(grant_log[0]), 0);
            check_eq("two_req_second", W'(grant_log[1]), 2);
        end

        // Single requester 0
        queue_group(0, 5, 10, 5, 10);
        wait_resp("single", 0, 100);
        check_eq("single_resp_msg", resp_msg, 30);
        check_eq("single_other_val", W'(resp_val[3:1]), 0);
        wait_drain("single", 100);

        // Result back-pressure on requester 3
        hold_mask = 4'b1000;
        queue_group(3, 93, 13, 3, 1);
        wait_resp("stall", 3, 100);
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_val", W'(resp_val[3]), 1);
            check_eq("stall_msg", resp_msg, 110);
            check_eq("stall_acc_rdy", W'(acc_resp_rdy), 0);
            @(negedge clk);
        end
        hold_mask = '0;
        @(negedge clk);
        check_eq("stall_release_rdy", W'(acc_resp_rdy), 1);
        wait_drain("stall", 100);

        // All four continuously valid for 8 groups
        grant_log.delete();
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < N; r++)
                queue_group(r, $urandom_range(255), $urandom_range(255),
                            $urandom_range(255), $urandom_range(255));
        wait_drain("all_four", 400);
        check_eq("all_four_groups", W'(grant_log.size()), 8);
        if (grant_log.size() == 8)
            for (int k = 0; k < 8; k++)
                check_eq($sformatf("all_four_order%0d", k), W'(grant_log[k]), W'(k % N));

        // Random gaps and back-pressure
        gap_pct     = 30;
        acc_rdy_pct = 60;
        rrdy_pct    = 60;
        acc_dly_pct = 50;
        for (int g = 0; g < 100; g++)
            for (int r = 0; r < N; r++)
                queue_group(r, $urandom_range(255), $urandom_range(255),
                            $urandom_range(255), $urandom_range(255));
        wait_drain("random", 40000);
        quiet_env();

        // Reset in the middle of a group
        queue_group(0, 1, 2, 3, 4);
        n = 0;
        while (n < 100 && acc_cnt != 2) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("abort_two_msgs", W'(acc_cnt), 2);
        reset = 1'b0;
        #1;
        check_eq("abort_busy", W'(busy), 0);
        check_eq("abort_grant", W'(grant), 0);
        check_eq("abort_handshakes", W'({req_rdy, resp_val, acc_req_val, acc_resp_rdy}), 0);
        check_eq("abort_resp_msg", resp_msg, 0);
        for (int r = 0; r < N; r++) begin
            msg_q[r].delete();
            exp_q[r].delete();
        end
        queue_group(1, 7, 8, 9, 10);
        repeat (3) @(negedge clk);
        grant_log.delete();
        #2 reset = 1'b1;
        wait_drain("post_reset", 200);
        check_eq("post_reset_groups", W'(grant_log.size()), 1);
        if (grant_log.size() == 1) check_eq("post_reset_grant", W'(grant_log[0]), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
